pulse_req_queue: RTL

PULSE_REQ_QUEUE -- requirements
Module: pulse_req_queue

---
 rtl/pulse_sync_pkg.sv | 22 ++
 rtl/sat_updown_cnt.sv | 50 +++++
 rtl/pulse_req_queue.sv | 104 ++++++++++
 3 files changed

// File: rtl/pulse_sync_pkg.sv
// Shared types and defaults for the pulse request queue feeding a
// handshake synchronizer.
package pulse_sync_pkg;

  localparam int unsigned DEF_CNT_W    = 4;
  localparam int unsigned DEF_HOLD_CYC = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    ISSUE,
    WAIT_DROP,
    WAIT_ACK,
    HOLD
  } pq_state_e;

  // Hold timer must represent HOLD_CYC; keep at least one bit when HOLD_CYC is 0.
  function automatic int unsigned hold_tmr_width(input int unsigned hold_cyc);
    return (hold_cyc < 2) ? 1 : $clog2(hold_cyc + 1);
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down pending-event counter with a full flag and a sticky
// overflow that records increments dropped while full.
module sat_updown_cnt
  import pulse_sync_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk_a,
  input  logic             rst_a,
  input  logic             inc_req,
  input  logic             dec,
  input  logic             clr_ovf,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic             overflow
);

  logic full;
  logic inc;
  logic drop;

  // A simultaneous decrement frees a slot, so a full counter still accepts.
  assign full = (cnt == '1);
  assign drop = inc_req & full & ~dec;
  assign inc  = inc_req & ~drop;

  always_comb begin
    cnt_next = cnt;
    if (inc && !dec) begin
      cnt_next = cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt_next = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_a) begin
    if (rst_a) begin
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pulse_req_queue.sv
// Queues source-domain pulses and issues them one at a time to a handshake
// synchronizer, waking its clock gate before the first request.
module pulse_req_queue
  import pulse_sync_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic             clk_a,
  input  logic             rst_a,
  input  logic             pulse_in,
  input  logic             sync_rdy,
  input  logic             clr_ovf,
  output logic             sync_vld,
  output logic             pulse_en,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             overflow
);

  localparam int unsigned      TMR_W     = hold_tmr_width(HOLD_CYC);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYC);

  pq_state_e        state;
  pq_state_e        state_next;
  logic [TMR_W-1:0] hold_tmr;
  logic [TMR_W-1:0] hold_tmr_next;
  logic [CNT_W-1:0] cnt_next;

  assign sync_vld = (state == ISSUE) & sync_rdy;

  sat_updown_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_a    (clk_a),
    .rst_a    (rst_a),
    .inc_req  (pulse_in),
    .dec      (sync_vld),
    .clr_ovf  (clr_ovf),
    .cnt      (pend_cnt),
    .cnt_next (cnt_next),
    .overflow (overflow)
  );

  always_comb begin
    state_next    = state;
    hold_tmr_next = hold_tmr;
    unique case (state)
      IDLE: begin
        if (pulse_in || (pend_cnt != '0)) state_next = WAKE;
      end
      WAKE: begin
        state_next = ISSUE;
      end
      ISSUE: begin
        if (sync_rdy) state_next = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (!sync_rdy) state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        // Look at the post-update count so an event arriving on the ack cycle
        // goes straight back to ISSUE instead of through HOLD.
        if (sync_rdy) begin
          if (cnt_next != '0) begin
            state_next = ISSUE;
          end else if (HOLD_CYC == 0) begin
            state_next = IDLE;
          end else begin
            state_next    = HOLD;
            hold_tmr_next = HOLD_LOAD;
          end
        end
      end
      HOLD: begin
        if (pulse_in || (pend_cnt != '0)) begin
          state_next    = ISSUE;
          hold_tmr_next = '0;
        end else if (hold_tmr <= TMR_W'(1)) begin
          state_next    = IDLE;
          hold_tmr_next = '0;
        end else begin
          hold_tmr_next = hold_tmr - TMR_W'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        hold_tmr_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_a) begin
    if (rst_a) begin
      state    <= IDLE;
      hold_tmr <= '0;
      pulse_en <= 1'b0;
    end else begin
      state    <= state_next;
      hold_tmr <= hold_tmr_next;
      pulse_en <= (state_next != IDLE);
    end
  end

endmodule
